wb_uart_tx: RTL and testbench



---
 rtl/wb_uart_pkg.sv | 30 +++
 rtl/wb_uart_tx_if.sv | 25 ++
 rtl/wb_uart_tx_fifo.sv | 56 +++++
 rtl/wb_uart_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_wb_uart_tx.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_uart_pkg.sv
// Shared constants, FSM state type and helpers for the Wishbone UART transmitter.
package wb_uart_pkg;

  localparam int unsigned DIV_W = 16;

  localparam logic [3:0] OFS_TXDATA  = 4'h0;
  localparam logic [3:0] OFS_STATUS  = 4'h4;
  localparam logic [3:0] OFS_DIVISOR = 4'h8;
  localparam logic [3:0] OFS_RSVD    = 4'hC;

  localparam int unsigned STAT_FULL      = 0;
  localparam int unsigned STAT_EMPTY     = 1;
  localparam int unsigned STAT_BUSY      = 2;
  localparam int unsigned STAT_OVR       = 3;
  localparam int unsigned STAT_PARITY    = 4;
  localparam int unsigned STAT_LEVEL_LSB = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/wb_uart_tx_if.sv
// Wishbone B4 pipelined bus bundle for the UART transmitter slave port.
interface wb_uart_tx_if;

  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_stall_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );

endinterface

// File: rtl/wb_uart_tx_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full only lands if a pop
// happens in the same cycle.
module wb_uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone B4 pipelined UART transmitter: FIFO-buffered byte stores serialised LSB first.
// Define WB_UART_TX_PARITY_EN to insert an even parity bit (8E1) instead of 8N1.
module wb_uart_tx
  import wb_uart_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_uart_tx_if.slave  wb,
  output logic         txd
);

  localparam int unsigned      LW      = $clog2(DEPTH) + 1;
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_FREQ / BAUD - 1);

  logic             req;
  logic [3:0]       ofs;
  logic             push;
  logic             ovr_clr;
  logic             div_wr;
  logic [DIV_W-1:0] divisor;
  logic             ovr;
  logic [31:0]      status;

  logic             fifo_pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LW-1:0]    fifo_level;

  tx_state_t        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             txd_d;
  logic             tick;

  logic unused_bus;
  assign unused_bus = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_dat_i[31:16],
                        wb.wb_sel_i[3:2]};

  assign req     = wb.wb_cyc_i && wb.wb_stb_i;
  assign ofs     = {wb.wb_adr_i[3:2], 2'b00};
  assign push    = req && wb.wb_we_i && (ofs == OFS_TXDATA) && wb.wb_sel_i[0];
  assign ovr_clr = req && wb.wb_we_i && (ofs == OFS_STATUS) && wb.wb_sel_i[0]
                   && wb.wb_dat_i[STAT_OVR];
  assign div_wr  = req && wb.wb_we_i && (ofs == OFS_DIVISOR);

  assign wb.wb_stall_o = 1'b0;

  wb_uart_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wb.wb_dat_i[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    status                             = '0;
    status[STAT_FULL]                  = fifo_full;
    status[STAT_EMPTY]                 = fifo_empty;
    status[STAT_BUSY]                  = (state_q != S_IDLE);
    status[STAT_OVR]                   = ovr;
`ifdef WB_UART_TX_PARITY_EN
    status[STAT_PARITY]                = 1'b1;
`else
    status[STAT_PARITY]                = 1'b0;
`endif
    status[STAT_LEVEL_LSB +: 8]        = 8'(fifo_level);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_err_o <= 1'b0;
      wb.wb_dat_o <= '0;
    end else begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_err_o <= 1'b0;
      wb.wb_dat_o <= '0;
      if (req) begin
        if (ofs == OFS_RSVD) begin
          wb.wb_err_o <= 1'b1;
        end else begin
          wb.wb_ack_o <= 1'b1;
          if (!wb.wb_we_i) begin
            unique case (ofs)
              OFS_STATUS:  wb.wb_dat_o <= status;
              OFS_DIVISOR: wb.wb_dat_o <= 32'(divisor);
              default:     wb.wb_dat_o <= '0;
            endcase
          end
        end
      end
    end
  end

  // A push that finds the FIFO full with no same-cycle pop is the only overrun case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor <= DIV_RST;
      ovr     <= 1'b0;
    end else begin
      if (div_wr && wb.wb_sel_i[0]) divisor[7:0]  <= wb.wb_dat_i[7:0];
      if (div_wr && wb.wb_sel_i[1]) divisor[15:8] <= wb.wb_dat_i[15:8];
      if (push && fifo_full && !fifo_pop) ovr <= 1'b1;
      else if (ovr_clr)                   ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd     <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd     <= txd_d;
    end
  end

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          par_d    = even_parity(fifo_rdata);
          cnt_d    = divisor;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          cnt_d   = divisor;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d = divisor;
          if (bit_q == 3'd7) begin
`ifdef WB_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_d   = divisor;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            par_d    = even_parity(fifo_rdata);
            cnt_d    = divisor;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // txd is registered from the next-state view so the line changes on the bit edge itself.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: bus access, frame timing, FIFO burst/overrun, reset.
module tb_wb_uart_tx;

  logic clk = 1'b0;
  logic rst_n;
  logic txd;

  always #5 clk = ~clk;

  wb_uart_tx_if bus ();

  wb_uart_tx #(
    .DEPTH    (16),
    .CLK_FREQ (100_000_000),
    .BAUD     (115_200)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus.slave),
    .txd   (txd)
  );

`ifdef WB_UART_TX_PARITY_EN
  localparam int          NBITS  = 11;
  localparam logic [31:0] ST_PAR = 32'h10;
`else
  localparam int          NBITS  = 10;
  localparam logic [31:0] ST_PAR = 32'h0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  always @(posedge clk) cycle <= cycle + 1;

  logic [7:0] rx_q[$];
  logic       rx_par_q[$];
  logic       rx_stop_q[$];
  int         rx_t[$];
  int         rx_div = 0;
  bit         rx_en  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (NBITS == 11 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  // Line receiver, sampling on falling clock edges at the programmed bit period.
  initial begin : rx
    logic [7:0] b;
    logic p, s;
    int t;
    forever begin
      @(negedge clk);
      if (rx_en && rst_n && txd === 1'b0) begin
        t = cycle;
        b = '0;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (rx_div + 1) @(negedge clk);
          b[i] = txd;
        end
`ifdef WB_UART_TX_PARITY_EN
        repeat (rx_div + 1) @(negedge clk);
        p = txd;
`endif
        repeat (rx_div + 1) @(negedge clk);
        s = txd;
        rx_q.push_back(b);
        rx_par_q.push_back(p);
        rx_stop_q.push_back(s);
        rx_t.push_back(t);
      end
    end
  end

  task automatic clear_rx();
    rx_q.delete();
    rx_par_q.delete();
    rx_stop_q.delete();
    rx_t.delete();
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
  endtask

  task automatic release_bus();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
  endtask

  task automatic bus_op(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rd,
                        output logic ack, output logic err);
    @(negedge clk);
    drive(we, adr, dat, sel);
    @(posedge clk);
    @(negedge clk);
    release_bus();
    rd  = bus.wb_dat_o;
    ack = bus.wb_ack_o;
    err = bus.wb_err_o;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                    input string tag);
    logic [31:0] d;
    logic a, e;
    bus_op(1'b1, adr, dat, sel, d, a, e);
    check({tag, "_ack"}, 32'(a), 32'd1);
  endtask

  task automatic rd_chk(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    logic a, e;
    bus_op(1'b0, adr, 32'h0, 4'hF, d, a, e);
    check(tag, d, exp);
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(rx_q.size()), 32'(n));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] d;
    logic a, e;

    rst_n = 1'b0;
    release_bus();
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
    check("rst_err", 32'(bus.wb_err_o), 32'd0);
    check("rst_dat", bus.wb_dat_o, 32'd0);
    rst_n = 1'b1;
    rd_chk(32'h4, 32'h2 | ST_PAR, "rst_status");
    rd_chk(32'h8, 32'd867, "rst_divisor");
    rd_chk(32'h0, 32'h0, "txdata_read");

    // 0x55 at DIVISOR=3: exact per-cycle line shape and BUSY release.
    wr(32'h8, 32'd3, 4'h3, "div3");
    @(negedge clk);
    drive(1'b1, 32'h0, 32'h55, 4'h1);
    @(posedge clk);
    @(negedge clk);
    release_bus();
    check("tx55_ack", 32'(bus.wb_ack_o), 32'd1);
    check("tx55_lat", 32'(txd), 32'd1);
    for (int k = 0; k < NBITS * 4; k++) begin
      @(negedge clk);
      check($sformatf("tx55_k%0d", k), 32'(txd), 32'(frame_bit(8'h55, k / 4)));
      if (k == NBITS * 4 - 1) drive(1'b0, 32'h4, 32'h0, 4'hF);
    end
    @(posedge clk);
    @(negedge clk);
    check("tx55_busy", bus.wb_dat_o, 32'h6 | ST_PAR);
    @(posedge clk);
    @(negedge clk);
    release_bus();
    check("tx55_idle", bus.wb_dat_o, 32'h2 | ST_PAR);

    // DIVISOR=0 burst of 17: no overrun, frames back-to-back.
    wr(32'h8, 32'd0, 4'h3, "div0");
    clear_rx();
    rx_div = 0;
    rx_en  = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'h0, 32'h0, 4'h1);
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("burst_ack%0d", i), 32'(bus.wb_ack_o), 32'd1);
      if (i < 16) drive(1'b1, 32'h0, 32'(i + 1), 4'h1);
      else release_bus();
    end
    bus_op(1'b0, 32'h4, 32'h0, 4'hF, d, a, e);
    check("burst_ovr", 32'(d[3]), 32'd0);
    wait_frames(17, 1000, "burst_frames");
    for (int i = 0; i < rx_q.size(); i++) begin
      check($sformatf("burst_byte%0d", i), 32'(rx_q[i]), 32'(i));
      check($sformatf("burst_stop%0d", i), 32'(rx_stop_q[i]), 32'd1);
      if (i > 0) check($sformatf("burst_gap%0d", i), 32'(rx_t[i] - rx_t[i-1]), 32'(NBITS));
    end
    rx_en = 1'b0;

    // DIVISOR=7, 18 writes: last dropped, OVR set then cleared.
    wr(32'h8, 32'd7, 4'h3, "div7");
    clear_rx();
    rx_div = 7;
    rx_en  = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'h0, 32'h20, 4'h1);
    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("ovr_ack%0d", i), 32'(bus.wb_ack_o), 32'd1);
      if (i < 17) drive(1'b1, 32'h0, 32'(32'h21 + i), 4'h1);
      else release_bus();
    end
    rd_chk(32'h4, 32'h100D | ST_PAR, "ovr_status");
    wr(32'h4, 32'h8, 4'h1, "ovr_clr");
    rd_chk(32'h4, 32'h1005 | ST_PAR, "ovr_cleared");
    wait_frames(17, 17 * NBITS * 8 + 200, "ovr_frames");
    for (int i = 0; i < rx_q.size(); i++)
      check($sformatf("ovr_byte%0d", i), 32'(rx_q[i]), 32'(32'h20 + i));
    repeat (NBITS * 8 * 2) @(negedge clk);
    check("ovr_nolast", 32'(rx_q.size()), 32'd17);
    rx_en = 1'b0;

    // Reserved offset and byte-wise divisor writes.
    bus_op(1'b0, 32'hC, 32'h0, 4'hF, d, a, e);
    check("rsvd_err", 32'(e), 32'd1);
    check("rsvd_ack", 32'(a), 32'd0);
    wr(32'h8, 32'h0123, 4'h3, "div_full");
    wr(32'h8, 32'h00AB, 4'h1, "div_lo");
    rd_chk(32'h8, 32'h01AB, "div_lo_rd");
    wr(32'h8, 32'hCD00, 4'h2, "div_hi");
    rd_chk(32'h8, 32'hCDAB, "div_hi_rd");

    // Reset mid-DATA of 0xA5 with another byte queued.
    wr(32'h8, 32'd3, 4'h3, "div3b");
    @(negedge clk);
    drive(1'b1, 32'h0, 32'hA5, 4'h1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 32'h0, 32'h3C, 4'h1);
    @(posedge clk);
    @(negedge clk);
    release_bus();
    repeat (9) @(negedge clk);
    check("rst_pre_txd", 32'(txd), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_txd", 32'(txd), 32'd1);
    check("rst_async_ack", 32'(bus.wb_ack_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk(32'h4, 32'h2 | ST_PAR, "rst_empty");
    rd_chk(32'h8, 32'd867, "rst_div_again");
    check("rst_txd_after", 32'(txd), 32'd1);

`ifdef WB_UART_TX_PARITY_EN
    wr(32'h8, 32'd1, 4'h3, "div1");
    clear_rx();
    rx_div = 1;
    rx_en  = 1'b1;
    wr(32'h0, 32'h07, 4'h1, "par_b0");
    wr(32'h0, 32'h07, 4'h1, "par_b1");
    wait_frames(2, 200, "par_frames");
    if (rx_q.size() == 2) begin
      check("par_byte", 32'(rx_q[0]), 32'h07);
      check("par_bit", 32'(rx_par_q[0]), 32'd1);
      check("par_stop", 32'(rx_stop_q[0]), 32'd1);
      check("par_len", 32'(rx_t[1] - rx_t[0]), 32'd22);
    end
    rx_en = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
